ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have the parameter C_DATA_WIDTH, default 64: stream and RAM word width in bits.
REQ-002 The block SHALL have the parameter C_ADDR_SIZE, default 9: RAM address width; the RAM depth is 2^C_ADDR_SIZE words.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have the port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have the port cmd_valid, input, 1 bit: a read command is present.
REQ-006 The block SHALL have the port cmd_ready, output, 1 bit: the block accepts a command.
REQ-007 The block SHALL have the port cmd_addr, input, C_ADDR_SIZE bits: first word address.
REQ-008 The block SHALL have the port cmd_len, input, C_ADDR_SIZE+1 bits: word count, 0 to 2^C_ADDR_SIZE.
REQ-009 The block SHALL have the port ram_reb, output, 1 bit: RAM read-port enable.
REQ-010 The block SHALL have the port ram_addrb, output, C_ADDR_SIZE bits: RAM read address.
REQ-011 The block SHALL have the port ram_dob, input, C_DATA_WIDTH bits: RAM read data, valid the cycle after ram_reb.
REQ-012 The block SHALL have the ports m_axis_tdata (output, C_DATA_WIDTH bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit): the AXI4-Stream master.
REQ-013 The block SHALL have the port busy, output, 1 bit: a command is in progress.
REQ-014 The block SHALL have the port done, output, 1 bit: a one-cycle pulse at command completion.

Function
REQ-015 The block SHALL implement the states IDLE, READ and DRAIN.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command handshake is cmd_valid&&cmd_ready.
REQ-017 On a handshake with cmd_len>0, the block SHALL move IDLE->READ, latch cmd_addr and cmd_len, and set busy=1.
REQ-018 On a handshake with cmd_len==0, the block SHALL stay in IDLE, emit no beat, and pulse done in the following cycle.
REQ-019 In READ, ram_reb SHALL be asserted when remaining>0 and (occ + pending - pop) < 2, where:
- occ is the output-buffer occupancy (0 to 2);
- pending is ram_reb of the previous cycle;
- pop is m_axis_tvalid&&m_axis_tready.
REQ-020 Each ram_reb SHALL present the current address, then increment the address modulo 2^C_ADDR_SIZE (wrap 2^C_ADDR_SIZE-1 -> 0) and decrement remaining.
REQ-021 ram_dob SHALL be captured into the 2-entry output buffer at the edge ending the cycle after ram_reb; the buffer SHALL never overflow.
REQ-022 Latency SHALL be: handshake at edge E0, ram_reb in cycle 1, first m_axis_tvalid in cycle 3.
REQ-023 Sustained throughput SHALL be 1 beat per cycle while m_axis_tready=1.
REQ-024 m_axis_tdata and m_axis_tlast SHALL hold stable while tvalid=1 and tready=0 (AXI4-Stream rule).
REQ-025 m_axis_tlast SHALL be 1 exactly on beat number cmd_len of the command.
REQ-026 The block SHALL move READ->DRAIN when remaining reaches 0.
REQ-027 The block SHALL move DRAIN->IDLE on the tlast handshake, pulsing done=1 and setting busy=0 in that same cycle.
REQ-028 cmd_ready SHALL rise the cycle after the tlast handshake, so back-to-back commands have a 1-cycle gap plus latency.
REQ-029 cmd_len=2^C_ADDR_SIZE SHALL read the whole RAM once, wrapping to cmd_addr.

Reset
REQ-030 On rstn=0 the block SHALL immediately force IDLE with all of the following:
- cmd_ready=1, ram_reb=0, ram_addrb=0;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- busy=0, done=0;
- buffer empty, pending=0.
REQ-031 A reset in the middle of a command SHALL discard the command and any buffered or in-flight data without emitting a partial tlast.
REQ-032 After rstn is released, the block SHALL accept a command on the first rising edge.

Structure
REQ-033 The state encoding localparams and the C_DATA_WIDTH/C_ADDR_SIZE defaults SHALL be placed in the shared StreamIF package/include.
REQ-034 The 2-entry output buffer SHALL be one sub-module, stream_skid_buffer (parameter C_DATA_WIDTH, with in/out valid/ready and occupancy output).
REQ-035 dualport_ram SHALL be instantiated externally, not inside this block.

Verification
REQ-036 Directed test: addr=0, len=4, tready=1 -> beats RAM[0..3] in consecutive cycles 3-6, tlast on beat 4, done 1 pulse.
REQ-037 Directed test: addr=510, len=4 (C_ADDR_SIZE=9) -> ram_addrb 510, 511, 0, 1; data in that order.
REQ-038 Directed test: len=8 with tready toggling 1010... -> no lost or duplicated beat, data stable while stalled, ram_reb never issued when the buffer plus in-flight data is 2.
REQ-039 Directed test: len=0 -> no tvalid, done pulses once, cmd_ready stays 1.
REQ-040 Directed test: rstn low after beat 2 of len=6 -> tvalid=0 immediately, no tlast; a new command with len=2 completes correctly.
REQ-041 Directed test: len=512 -> 512 beats, addresses wrap back to the start, exactly one tlast.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM-to-AXI4-Stream reader: default widths and FSM encoding.
package ram_stream_reader_pkg;

  localparam int unsigned C_DATA_WIDTH_DEF = 64;
  localparam int unsigned C_ADDR_SIZE_DEF  = 9;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_READ  = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ram_stream_reader_skid_buffer.sv
// Two-entry FIFO between the RAM read port and the stream master; output data comes straight from storage flops.
module stream_skid_buffer #(
  parameter int unsigned C_DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic [1:0]              occupancy
);

  logic [C_DATA_WIDTH-1:0] data0;
  logic [C_DATA_WIDTH-1:0] data1;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    push;
  logic                    pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? data1 : data0;
  assign occupancy = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry storage, pointers and occupancy; reset clears storage so the data output reads zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data0  <= '0;
      data1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) data1 <= in_data;
        else        data0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads cmd_len consecutive words from an external synchronous RAM and streams them out on AXI4-Stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = C_DATA_WIDTH_DEF,
  parameter int unsigned C_ADDR_SIZE  = C_ADDR_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_ADDR_SIZE-1:0]  cmd_addr,
  input  logic [C_ADDR_SIZE:0]    cmd_len,
  output logic                    ram_reb,
  output logic [C_ADDR_SIZE-1:0]  ram_addrb,
  input  logic [C_DATA_WIDTH-1:0] ram_dob,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BUF_W = C_DATA_WIDTH + 1;
  localparam logic [C_ADDR_SIZE-1:0] ADDR_ONE = {{(C_ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [C_ADDR_SIZE:0]   LEN_ONE  = {{C_ADDR_SIZE{1'b0}}, 1'b1};

  logic [ST_W-1:0]        state;
  logic [ST_W-1:0]        state_nxt;
  logic [C_ADDR_SIZE-1:0] addr;
  logic [C_ADDR_SIZE-1:0] addr_nxt;
  logic [C_ADDR_SIZE:0]   remaining;
  logic [C_ADDR_SIZE:0]   remaining_nxt;
  logic                   pending;
  logic                   pending_last;
  logic                   last_rd;
  logic                   done_q;
  logic                   done_nxt;
  logic [2:0]             fill;
  logic                   pop;
  logic [1:0]             occ;
  logic                   buf_in_ready;
  logic                   buf_valid;
  logic [BUF_W-1:0]       buf_out;

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign ram_addrb     = addr;
  assign m_axis_tvalid = buf_valid;
  assign m_axis_tdata  = buf_out[C_DATA_WIDTH-1:0];
  assign m_axis_tlast  = buf_valid && buf_out[C_DATA_WIDTH];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // State, read pointer, word counter, in-flight read flag and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      addr         <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr         <= addr_nxt;
      remaining    <= remaining_nxt;
      pending      <= ram_reb;
      pending_last <= last_rd;
      done_q       <= done_nxt;
    end
  end

  // Next state and read issue; a read is issued only if buffer plus in-flight data stays below two.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    ram_reb       = 1'b0;
    last_rd       = 1'b0;
    fill          = 3'(occ) + 3'(pending) - 3'(pop);
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            state_nxt     = ST_READ;
            addr_nxt      = cmd_addr;
            remaining_nxt = cmd_len;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_READ: begin
        if ((remaining != '0) && (fill < 3'd2)) begin
          ram_reb       = 1'b1;
          addr_nxt      = addr + ADDR_ONE;
          remaining_nxt = remaining - LEN_ONE;
          last_rd       = (remaining == LEN_ONE);
          if (last_rd) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_axis_tlast) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output buffer; each entry carries the word plus its last-beat tag.
  stream_skid_buffer #(
    .C_DATA_WIDTH (BUF_W)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (pending),
    .in_ready  (buf_in_ready),
    .in_data   ({pending_last, ram_dob}),
    .out_valid (buf_valid),
    .out_ready (m_axis_tready),
    .out_data  (buf_out),
    .occupancy (occ)
  );

  // Returning RAM data must always find room in the buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) pending |-> buf_in_ready);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural synchronous RAM.
module tb_ram_stream_reader;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 9;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          ram_reb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [DEPTH];
  logic [DW:0]   exp_beat_q [$];
  logic [AW-1:0] exp_addr_q [$];

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int tlast_cnt = 0;
  int done_cnt = 0;
  int issued = 0;
  int popped = 0;
  bit toggle_ready = 1'b0;
  logic          prev_v;
  logic          prev_r;
  logic [DW:0]   prev_beat;

  ram_stream_reader #(.C_DATA_WIDTH(DW), .C_ADDR_SIZE(AW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .ram_reb       (ram_reb),
    .ram_addrb     (ram_addrb),
    .ram_dob       (ram_dob),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM read port: data one cycle after the enable.
  always @(posedge clk) if (ram_reb) ram_dob <= ram[ram_addrb];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sink ready: constant high or alternating, changed just after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) m_axis_tready = ~m_axis_tready;
      else              m_axis_tready = 1'b1;
    end
  end

  // Monitor: read addresses, read credit, beat data, stall stability and done behaviour.
  always @(negedge clk) begin
    if (!rstn) begin
      issued = 0;
      popped = 0;
      prev_v = 1'b0;
    end else begin
      if (ram_reb) begin
        chk("reb_credit", 128'((issued - popped - int'(m_axis_tvalid && m_axis_tready)) < 2), 128'(1));
        chk("addr_avail", 128'(exp_addr_q.size() > 0), 128'(1));
        if (exp_addr_q.size() > 0) chk("ram_addrb", 128'(ram_addrb), 128'(exp_addr_q.pop_front()));
      end
      if (prev_v && !prev_r)
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        pop_cnt++;
        chk("beat_avail", 128'(exp_beat_q.size() > 0), 128'(1));
        if (exp_beat_q.size() > 0) chk("beat", {m_axis_tlast, m_axis_tdata}, 128'(exp_beat_q.pop_front()));
        if (m_axis_tlast) begin
          tlast_cnt++;
          chk("ready_at_last", 128'(cmd_ready), 128'(0));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_idle", {busy, cmd_ready}, 128'(2'b01));
      end
      issued += int'(ram_reb);
      popped += int'(m_axis_tvalid && m_axis_tready);
      prev_v    = m_axis_tvalid;
      prev_r    = m_axis_tready;
      prev_beat = {m_axis_tlast, m_axis_tdata};
    end
  end

  // Called just after a rising edge; handshake happens on the next edge.
  task automatic issue(input int addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = AW'(addr + i);
      exp_addr_q.push_back(a);
      exp_beat_q.push_back({(i == len - 1), ram[a]});
    end
    chk("cmd_ready_pre", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = (AW+1)'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 128'(done_cnt != start), 128'(1));
  endtask

  task automatic finish_cmd(input string tag, input int d0, input int p0, input int t0,
                            input int beats, input int lasts);
    wait_done(d0, 3000);
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, 128'(done_cnt - d0), 128'(1));
    chk({tag, "_beats"}, 128'(pop_cnt - p0), 128'(beats));
    chk({tag, "_tlasts"}, 128'(tlast_cnt - t0), 128'(lasts));
    chk({tag, "_sb_empty"}, 128'(exp_beat_q.size() + exp_addr_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, p0, t0, first;
    for (int i = 0; i < DEPTH; i++) ram[i] = (64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hC0DE_0000_0000_0000;
    rstn = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cmd_ready, ram_reb, m_axis_tvalid, m_axis_tlast, busy, done}, 128'(6'b100000));
    chk("rst_addrb", 128'(ram_addrb), 128'(0));
    chk("rst_tdata", 128'(m_axis_tdata), 128'(0));

    // Basic read with latency check, accepted on the first edge after reset release
    @(posedge clk);
    #1;
    rstn = 1'b1;
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt; first = 0;
    issue(0, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("reb_cycle1", {ram_reb, busy}, 128'(2'b11));
      if (m_axis_tvalid && first == 0) first = k;
      if (k == 7) chk("beats_by_c6", 128'(pop_cnt - p0), 128'(4));
    end
    chk("first_valid_cycle", 128'(first), 128'(3));
    finish_cmd("t1", d0, p0, t0, 4, 1);

    // Address wrap at top of RAM
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(510, 4);
    finish_cmd("t2", d0, p0, t0, 4, 1);

    // Back-pressure with alternating ready
    toggle_ready = 1'b1;
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(100, 8);
    finish_cmd("t3", d0, p0, t0, 8, 1);
    toggle_ready = 1'b0;

    // Zero-length command
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(42, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("len0_idle", {cmd_ready, m_axis_tvalid, ram_reb}, 128'(3'b100));
    end
    chk("len0_done_once", 128'(done_cnt - d0), 128'(1));
    @(posedge clk);
    #1;

    // Reset in the middle of a command, then a fresh command
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(20, 6);
    first = 0;
    while (pop_cnt < p0 + 2 && first < 200) begin
      @(negedge clk);
      first++;
    end
    chk("beat2_seen", 128'(pop_cnt >= p0 + 2), 128'(1));
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_beat_q.delete();
    exp_addr_q.delete();
    #1;
    chk("rst_mid_tvalid", 128'(m_axis_tvalid), 128'(0));
    @(negedge clk);
    chk("rst_mid_state", {m_axis_tlast, busy, cmd_ready, ram_reb, done}, 128'(5'b00100));
    chk("rst_mid_no_tlast", 128'(tlast_cnt - t0), 128'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(300, 2);
    finish_cmd("t5", d0, p0, t0, 2, 1);

    // Full-RAM read starting mid-array
    d0 = done_cnt; p0 = pop_cnt; t0 = tlast_cnt;
    issue(37, 512);
    finish_cmd("t6", d0, p0, t0, 512, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
